// File: rtl/dcfifo_ch_scheduler.sv
// dcfifo_ch_scheduler: time-division channel select/flush scheduler for a dual-clock FIFO bank
module dcfifo_ch_scheduler #(
  parameter int NCH       = 4,
  parameter int CW        = 2,
  parameter int DWELL_W   = 16,
  parameter int FLUSH_CYC = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NCH-1:0]     ch_mask,
  output logic [NCH-1:0]     sel,
  output logic               FRST,
  output logic [CW-1:0]      cur_ch,
  output logic               busy,
  output logic               win_done
);
  localparam int FW = $clog2(FLUSH_CYC + 1);
  typedef enum logic [1:0] {IDLE, FLUSH, RUN} state_t;
  state_t state;
  logic [NCH-1:0] mask_r;
  logic [DWELL_W-1:0] dwell_r, dcnt;
  logic [FW-1:0] fcnt;
  logic [CW-1:0] lo_ch, nx_ch, lo_r;
  logic f_end, d_end;
  always_comb begin
    lo_ch = '0;
    lo_r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      lo_ch = ch_mask[i] ? CW'(i) : lo_ch;
      lo_r = mask_r[i] ? CW'(i) : lo_r;
    end
    nx_ch = lo_r;
    for (int i = NCH - 1; i >= 0; i--)
      nx_ch = (mask_r[i] && CW'(i) > cur_ch) ? CW'(i) : nx_ch;
  end
  assign f_end = fcnt == FW'(FLUSH_CYC - 1);
  assign d_end = dcnt == dwell_r - DWELL_W'(1);
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      mask_r <= '0;
      dwell_r <= '0;
      dcnt <= '0;
      fcnt <= '0;
      cur_ch <= '0;
      sel <= '0;
      FRST <= 1'b1;
      busy <= 1'b0;
      win_done <= 1'b0;
    end else begin
      win_done <= 1'b0;
      if (stop) begin
        state <= IDLE;
        dcnt <= '0;
        fcnt <= '0;
        sel <= '0;
        FRST <= 1'b1;
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start && |ch_mask) begin
            state <= FLUSH;
            mask_r <= ch_mask;
            dwell_r <= (dwell == '0) ? DWELL_W'(1) : dwell;
            cur_ch <= lo_ch;
            fcnt <= '0;
            busy <= 1'b1;
          end
          FLUSH: if (f_end) begin
            state <= RUN;
            dcnt <= '0;
            sel <= NCH'(1) << cur_ch;
            FRST <= 1'b0;
            // registered pulse must already be high on a one-cycle window
            win_done <= dwell_r == DWELL_W'(1);
          end else begin
            fcnt <= fcnt + FW'(1);
          end
          RUN: if (d_end) begin
            state <= FLUSH;
            cur_ch <= nx_ch;
            fcnt <= '0;
            sel <= '0;
            FRST <= 1'b1;
          end else begin
            dcnt <= dcnt + DWELL_W'(1);
            win_done <= dcnt + DWELL_W'(1) == dwell_r - DWELL_W'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dcfifo_ch_scheduler.sv
// tb_dcfifo_ch_scheduler: scoreboard bench checking per-cycle outputs of dcfifo_ch_scheduler
module tb_dcfifo_ch_scheduler;
  localparam int NCH = 4, CW = 2, DW = 16, FL = 8;
  logic CLK = 1'b0, RST = 1'b1, start = 1'b0, stop = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic [NCH-1:0] ch_mask = '0;
  logic [NCH-1:0] sel;
  logic FRST, busy, win_done;
  logic [CW-1:0] cur_ch;
  typedef logic [8:0] snap_t;
  snap_t sb[$];
  snap_t exp_s;
  int n_cmp = 0, n_bad = 0;
  always #5 CLK = ~CLK;
  dcfifo_ch_scheduler #(.NCH(NCH), .CW(CW), .DWELL_W(DW), .FLUSH_CYC(FL)) dut (
    .CLK(CLK), .RST(RST), .start(start), .stop(stop), .dwell(dwell), .ch_mask(ch_mask),
    .sel(sel), .FRST(FRST), .cur_ch(cur_ch), .busy(busy), .win_done(win_done)
  );
  function automatic snap_t mk(logic [3:0] s, logic f, logic b, logic w, logic [1:0] c);
    return {s, f, b, w, c};
  endfunction
  function automatic snap_t obs();
    return {sel, FRST, busy, win_done, cur_ch};
  endfunction
  task automatic push_win(int ch, int dw);
    for (int i = 0; i < FL; i++) sb.push_back(mk(4'b0, 1'b1, 1'b1, 1'b0, 2'(ch)));
    for (int i = 0; i < dw; i++) sb.push_back(mk(4'(1 << ch), 1'b0, 1'b1, i == dw - 1, 2'(ch)));
  endtask
  task automatic push_flush1(int ch);
    sb.push_back(mk(4'b0, 1'b1, 1'b1, 1'b0, 2'(ch)));
  endtask
  task automatic push_idle(int n, int ch);
    for (int i = 0; i < n; i++) sb.push_back(mk(4'b0, 1'b1, 1'b0, 1'b0, 2'(ch)));
  endtask
  task automatic go_idle();
    @(negedge CLK);
    stop = 1'b1;
    @(posedge CLK);
    #1 stop = 1'b0;
  endtask
  task automatic kick(logic [3:0] m, int d);
    @(negedge CLK);
    start = 1'b1;
    ch_mask = m;
    dwell = DW'(d);
  endtask
  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1 sb.push_back(mk(4'b0, 1'b1, 1'b0, 1'b0, 2'd0));
    exp_s = sb.pop_front();
    n_cmp++;
    if (obs() !== exp_s) begin n_bad++; $display("FAIL reset: got %b want %b", obs(), exp_s); end
    @(negedge CLK) RST = 1'b0;
    push_idle(2, 0);
    while (sb.size() != 0) begin
      @(posedge CLK);
      #1 exp_s = sb.pop_front();
      n_cmp++;
      if (obs() !== exp_s) begin n_bad++; $display("FAIL reset_idle: got %b want %b", obs(), exp_s); end
    end
  endtask
  task automatic test_single();
    push_win(0, 5);
    push_flush1(0);
    kick(4'b0001, 5);
    while (sb.size() != 0) begin
      @(posedge CLK);
      #1 start = 1'b0;
      exp_s = sb.pop_front();
      n_cmp++;
      if (obs() !== exp_s) begin n_bad++; $display("FAIL single: got %b want %b", obs(), exp_s); end
    end
    go_idle();
  endtask
  task automatic test_rotation();
    push_win(1, 3);
    push_win(3, 3);
    push_win(1, 3);
    push_flush1(3);
    kick(4'b1010, 3);
    while (sb.size() != 0) begin
      @(posedge CLK);
      #1 start = 1'b0;
      exp_s = sb.pop_front();
      n_cmp++;
      if (obs() !== exp_s) begin n_bad++; $display("FAIL rotation: got %b want %b", obs(), exp_s); end
    end
    go_idle();
  endtask
  task automatic test_dwell_zero();
    push_win(2, 1);
    push_flush1(2);
    kick(4'b0100, 0);
    while (sb.size() != 0) begin
      @(posedge CLK);
      #1 start = 1'b0;
      exp_s = sb.pop_front();
      n_cmp++;
      if (obs() !== exp_s) begin n_bad++; $display("FAIL dwell_zero: got %b want %b", obs(), exp_s); end
    end
    go_idle();
  endtask
  task automatic test_ignored_start();
    int i;
    push_idle(4, 2);
    kick(4'b0000, 3);
    while (sb.size() != 0) begin
      @(posedge CLK);
      #1 start = 1'b0;
      exp_s = sb.pop_front();
      n_cmp++;
      if (obs() !== exp_s) begin n_bad++; $display("FAIL mask_zero: got %b want %b", obs(), exp_s); end
    end
    push_win(0, 4);
    push_win(0, 4);
    kick(4'b0001, 4);
    i = 0;
    while (sb.size() != 0) begin
      @(posedge CLK);
      #1 start = 1'b0;
      i++;
      exp_s = sb.pop_front();
      n_cmp++;
      if (obs() !== exp_s) begin n_bad++; $display("FAIL busy_start: got %b want %b", obs(), exp_s); end
      if (i == 3 || i == 10) begin start = 1'b1; dwell = DW'(7); ch_mask = 4'b1000; end
    end
    go_idle();
  endtask
  task automatic test_stop();
    int i;
    push_win(1, 2);
    push_idle(3, 1);
    kick(4'b0010, 2);
    i = 0;
    while (sb.size() != 0) begin
      @(posedge CLK);
      #1 start = 1'b0;
      stop = 1'b0;
      i++;
      exp_s = sb.pop_front();
      n_cmp++;
      if (obs() !== exp_s) begin n_bad++; $display("FAIL stop_win_done: got %b want %b", obs(), exp_s); end
      if (i == FL + 2) stop = 1'b1;
    end
    push_idle(3, 1);
    kick(4'b0001, 2);
    stop = 1'b1;
    while (sb.size() != 0) begin
      @(posedge CLK);
      #1 start = 1'b0;
      stop = 1'b0;
      exp_s = sb.pop_front();
      n_cmp++;
      if (obs() !== exp_s) begin n_bad++; $display("FAIL start_stop_idle: got %b want %b", obs(), exp_s); end
    end
  endtask
  task automatic test_async_rst();
    push_win(1, 6);
    kick(4'b0010, 6);
    for (int i = 0; i < FL + 2; i++) begin
      @(posedge CLK);
      #1 start = 1'b0;
      exp_s = sb.pop_front();
      n_cmp++;
      if (obs() !== exp_s) begin n_bad++; $display("FAIL pre_rst: got %b want %b", obs(), exp_s); end
    end
    sb.delete();
    #2 RST = 1'b1;
    #1 sb.push_back(mk(4'b0, 1'b1, 1'b0, 1'b0, 2'd0));
    exp_s = sb.pop_front();
    n_cmp++;
    if (obs() !== exp_s) begin n_bad++; $display("FAIL async_rst: got %b want %b", obs(), exp_s); end
    @(negedge CLK) RST = 1'b0;
    push_win(2, 2);
    kick(4'b1100, 2);
    while (sb.size() != 0) begin
      @(posedge CLK);
      #1 start = 1'b0;
      exp_s = sb.pop_front();
      n_cmp++;
      if (obs() !== exp_s) begin n_bad++; $display("FAIL post_rst: got %b want %b", obs(), exp_s); end
    end
    go_idle();
  endtask
  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_dwell_zero();
    test_ignored_start();
    test_stop();
    test_async_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within 200000 time units");
    $fatal(1);
  end
endmodule

// File: doc/dcfifo_ch_scheduler.md
# dcfifo_ch_scheduler

Time-division scheduler for a bank of single-channel dual-clock delay FIFOs. It drives each FIFO's channel-select and flush inputs, so exactly one channel owns the datapath at a time. Every window is preceded by a fixed flush period. The block sits upstream of the FIFO bank in the CLK domain, and all its outputs are registered so they can feed the FIFOs' select/flush inputs directly.

## Interface
Parameters:
- NCH, 4, number of FIFO channels (2..16)
- CW, 2, channel index width, equal to clog2(NCH)
- DWELL_W, 16, width of the dwell-length input and counter
- FLUSH_CYC, 8, flush cycles before each window (≥1)

Ports:
- CLK  in  1  single clock; all logic on posedge
- RST  in  1  reset, asynchronous and active-high
- start  in  1  single-cycle pulse that begins scheduling
- stop  in  1  single-cycle pulse that aborts scheduling
- dwell  in  DWELL_W  window length in cycles; sampled on accepted start
- ch_mask  in  NCH  channels included in rotation; sampled on accepted start
- sel  out  NCH  one-hot select of the active channel; zero outside RUN
- FRST  out  1  flush to all FIFOs; high in IDLE and FLUSH
- cur_ch  out  CW  index of the current/next channel
- busy  out  1  high in FLUSH or RUN
- win_done  out  1  one-cycle pulse on the last cycle of each window

## Operation
- States:
  - IDLE (sel=0, FRST=1, busy=0)
  - FLUSH (sel=0, FRST=1, busy=1)
  - RUN (sel=onehot(cur_ch), FRST=0, busy=1)
- IDLE→FLUSH: start=1, stop=0, ch_mask≠0.
  - Latch mask_r←ch_mask.
  - Latch dwell_r←(dwell==0 ? 1 : dwell).
  - cur_ch←lowest set bit of ch_mask.
  - Flush counter←0.
- If start arrives with ch_mask==0, it is ignored and the block stays in IDLE.
- FLUSH→RUN: the flush counter reaches FLUSH_CYC-1. The dwell counter is cleared.
- RUN→FLUSH: the dwell counter reaches dwell_r-1.
  - win_done=1 on that cycle.
  - cur_ch←next set bit of mask_r strictly above cur_ch, wrapping to the lowest set bit.
  - With a single-bit mask, the block re-selects the same channel but still passes through FLUSH.
- stop=1 in any state → IDLE on the next edge.
  - Counters cleared. No win_done is generated.
  - stop takes priority over a simultaneous start or window end.
- start while busy is ignored. Changes to dwell or ch_mask while busy have no effect until the next accepted start.
- Flush counter width: clog2(FLUSH_CYC+1). Dwell counter width: DWELL_W. Neither counter can overflow, because comparisons end the count before wrap.
- System constraint (not checked): dwell must exceed the FIFO read threshold plus synchronizer delay, or no data emerges during the window.

## Timing
- Reset values while RST=1: state IDLE, sel=0, FRST=1, cur_ch=0, busy=0, win_done=0, counters 0.
- start sampled at edge 0:
  - FLUSH occupies cycles 1..FLUSH_CYC (FRST=1, busy=1).
  - sel is active on cycles FLUSH_CYC+1..FLUSH_CYC+dwell_r.
  - win_done is high on cycle FLUSH_CYC+dwell_r.
  - The next FLUSH starts on cycle FLUSH_CYC+dwell_r+1.
- Period per channel: FLUSH_CYC+dwell_r cycles. sel is never high on the same cycle as FRST.
- sel changes from zero to one-hot, and back to zero, on the same edge that FRST falls or rises.
- cur_ch updates on the edge that enters FLUSH, so it is stable for the whole FLUSH and RUN of a window.
- stop at edge k: on cycle k+1, sel=0, FRST=1, busy=0.
- Asynchronous RST mid-window forces the reset values immediately, without waiting for a clock edge.

## Test plan
- Reset, then one start with FLUSH_CYC=8, dwell=5, ch_mask=4'b0001 → FRST high on cycles 1–8, sel=0001 on 9–13, win_done on 13, FRST high again from 14.
- ch_mask=4'b1010, dwell=3, run for 3 windows → cur_ch sequence 1,3,1, sel 0010/1000/0010, each window 3 cycles with 8 flush cycles between.
- dwell=0, ch_mask=4'b0100 → behaves as dwell=1: sel=0100 for exactly 1 cycle, with win_done on that cycle.
- start with ch_mask=0 → busy stays 0 and FRST stays 1; a start while busy with a different dwell/mask → no change to the current schedule.
- stop on the same cycle as win_done in RUN → next cycle IDLE, sel=0, FRST=1, cur_ch unchanged; a simultaneous start+stop in IDLE → stays IDLE.
- RST asserted asynchronously mid-RUN with sel=0010 → sel=0, FRST=1, busy=0 before the next CLK edge; a start after RST release begins from the lowest mask bit.
